hfrv_trace_buffer: RTL and testbench
====================================

# hfrv_trace_buffer

Synthesizable on-chip trace capture for the HF-RISCV core. It records retired-instruction and data-access events into a parametrised first-word-fall-through (FWFT) FIFO, with three capture modes: off, stream, and PC-triggered. It sits beside the core in `dut_top`, and the bench monitor drains it through a valid/ready port. It is the hardware successor to the software-only monitor callbacks for process, opcode and data-access debug.

## Interface
- `ADDR_W`, default 32: width of the PC and data address.
- `DATA_W`, default 32: width of the instruction word and data word.
- `DEPTH`, default 16: number of FIFO entries. Must be a power of 2 and ≥ 2.
- `DROP_W`, default 16: width of the saturating drop counter.
- `clk`  in  1: single clock, rising-edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `cfg_mode`  in  2: capture mode, sampled on `cfg_start`. 0 = OFF, 1 = STREAM, 2 = TRIGGER, 3 = reserved (treated as OFF).
- `cfg_start`  in  1: single-cycle pulse that starts capture in `cfg_mode`.
- `cfg_stop`  in  1: single-cycle pulse that returns the block to OFF. FIFO contents are kept.
- `cfg_flush`  in  1: single-cycle pulse that empties the FIFO and clears `drop_cnt`.
- `trig_pc`  in  ADDR_W: trigger address used in TRIGGER mode.
- `ins_valid`, `ins_pc`, `ins_word`  in  1/ADDR_W/DATA_W: retired-instruction event.
- `dat_valid`, `dat_addr`, `dat_data`, `dat_we`  in  1/ADDR_W/DATA_W/1: data-access event.
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_entry`  out  2+ADDR_W+DATA_W: head entry, packed as {ch, we, addr, data}. `ch` = 0 for instruction, 1 for data.
- `level`  out  $clog2(DEPTH)+1: current occupancy.
- `drop_cnt`  out  DROP_W: count of events lost, saturating.
- `state`  out  2: current FSM state.

## Operation
- FSM states: OFF (0), ARMED (1), CAPTURE (2), FROZEN (3).
- Transitions:
  - `cfg_start` with STREAM → CAPTURE.
  - `cfg_start` with TRIGGER → ARMED.
  - `cfg_start` with OFF or reserved mode → OFF.
  - `cfg_start` is accepted in any state and restarts the FSM. It does not flush.
  - `cfg_stop` → OFF from any state. If `cfg_stop` and `cfg_start` arrive in the same cycle, stop wins.
  - ARMED → CAPTURE when `ins_valid` is high and `ins_pc == trig_pc`. The matching instruction is the first entry captured.
  - CAPTURE in TRIGGER mode → FROZEN when the FIFO reaches `DEPTH`.
  - FROZEN is left only via `cfg_start` or `cfg_stop`. Draining the FIFO does not resume capture.
- Events are ignored and not counted in OFF, ARMED (except the match) and FROZEN.
- Arbitration in CAPTURE:
  - The FIFO accepts at most one write per cycle, and the instruction channel has priority.
  - A data event that loses arbitration goes into a 1-deep pending register. Pending is written on the next free cycle, ahead of a new data event.
  - A data event that arrives while pending is still occupied and not draining that cycle is dropped and counted.
- Full FIFO in STREAM mode: the write is dropped, `drop_cnt` increments, and pending is held.
- `drop_cnt` saturates at 2^DROP_W − 1. Two drops in one cycle (instruction and data) add 2, still saturating.
- `cfg_flush`:
  - Pointers, level, pending and `drop_cnt` go to 0 on the next edge. The FSM state is unchanged.
  - Any write or drop in the same cycle is discarded and not counted. Flush wins over read.
- FIFO pointers wrap modulo `DEPTH`. Simultaneous read and write at full or empty keeps `level` constant, except that a write to a full FIFO is only allowed when a read occurs in the same cycle.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - `state` = OFF.
  - `level` = 0, `out_valid` = 0.
  - `drop_cnt` = 0.
  - `out_entry` = 0 when empty.
  - Pending cleared.
  - FIFO memory is not reset.
- Event sampled at edge N is visible on `out_entry`/`out_valid` after edge N (1-cycle latency, FWFT).
- A pended data event appears no earlier than edge N+1.
- The handshake completes on an edge where `out_valid && out_ready`. `out_entry` advances combinationally from the new read pointer.
- `out_entry` must be stable while `out_valid && !out_ready`.
- FSM transitions take effect on the edge where the condition is sampled.
- Reset mid-capture discards everything; no partial entries survive.

## Structure
- Shared package `hfrv_trace_pkg` contains:
  - enum `trace_state_t` (OFF/ARMED/CAPTURE/FROZEN);
  - enum `trace_mode_t`;
  - constants `CH_INS` = 0 and `CH_DAT` = 1;
  - packed struct `trace_entry_t` parametrised via ADDR_W/DATA_W in the top.
- Sub-module `hfrv_trace_fifo`: generic FWFT FIFO with parameters WIDTH and DEPTH. It provides `wr_en`/`rd_en`/`flush`/`level` and asynchronous active-low reset.
- The top holds the FSM, arbiter, pending register and drop counter.

## Test plan
- **STREAM burst:** start STREAM, drive 5 `ins` events with pc 0x100..0x110 step 4, `out_ready` = 0. Expect `level` = 5 and entries in order with ch = 0. Then drain and expect `level` = 0.
- **Collision:** in one cycle, `ins_pc` = 0x200 and a data write to 0x8000 with data 0xDEAD. Expect the instruction entry first, the data entry next cycle with we = 1, and `drop_cnt` = 0.
- **Overflow:** DEPTH = 16, STREAM, `out_ready` = 0, 20 instruction events. Expect `level` = 16, `drop_cnt` = 4 and the FIFO holding the first 16 PCs.
- **Trigger:**
  - TRIGGER with `trig_pc` = 0x40, then pcs 0x30, 0x34, 0x40, 0x44. Expect ARMED, then CAPTURE on 0x40, with entries 0x40 and 0x44 only.
  - Fill to 16 entries: state goes to FROZEN and further events leave `drop_cnt` = 0.
- **Control races:**
  - `cfg_start` and `cfg_stop` together → OFF.
  - `cfg_flush` together with a write and a read → `level` = 0 and `drop_cnt` = 0.
  - `drop_cnt` forced near saturation (DROP_W = 4, 17 drops) → 15.
- **Reset mid-operation:** deassert `rst_n` asynchronously mid-capture with `level` = 7. Expect all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/hfrv_trace_buffer_pkg.sv
// Shared types and constants for the HF-RISCV trace capture block.
package hfrv_trace_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FROZEN  = 2'd3
    } trace_state_t;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STREAM  = 2'd1,
        MODE_TRIGGER = 2'd2,
        MODE_RSVD    = 2'd3
    } trace_mode_t;

    localparam logic CH_INS = 1'b0;
    localparam logic CH_DAT = 1'b1;

    localparam int TRACE_ADDR_W = 32;
    localparam int TRACE_DATA_W = 32;

    // Reference layout at default widths; the top re-declares it with its own parameters.
    typedef struct packed {
        logic                    ch;
        logic                    we;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

    function automatic trace_state_t start_state(input trace_mode_t mode);
        case (mode)
            MODE_STREAM:  return ST_CAPTURE;
            MODE_TRIGGER: return ST_ARMED;
            default:      return ST_OFF;
        endcase
    endfunction

endpackage

// File: rtl/hfrv_trace_buffer_if.sv
// Configuration, event and drain signals of the trace buffer, grouped as one bundle.
interface hfrv_trace_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [1:0]             cfg_mode;
    logic                   cfg_start;
    logic                   cfg_stop;
    logic                   cfg_flush;
    logic [ADDR_W-1:0]      trig_pc;
    logic                   ins_valid;
    logic [ADDR_W-1:0]      ins_pc;
    logic [DATA_W-1:0]      ins_word;
    logic                   dat_valid;
    logic [ADDR_W-1:0]      dat_addr;
    logic [DATA_W-1:0]      dat_data;
    logic                   dat_we;
    logic                   out_valid;
    logic                   out_ready;
    logic [1+1+ADDR_W+DATA_W-1:0] out_entry;
    logic [LVL_W-1:0]       level;
    logic [DROP_W-1:0]      drop_cnt;
    logic [1:0]             state;

    modport slave (
        input  cfg_mode, cfg_start, cfg_stop, cfg_flush, trig_pc,
        input  ins_valid, ins_pc, ins_word,
        input  dat_valid, dat_addr, dat_data, dat_we,
        input  out_ready,
        output out_valid, out_entry, level, drop_cnt, state
    );

    modport master (
        output cfg_mode, cfg_start, cfg_stop, cfg_flush, trig_pc,
        output ins_valid, ins_pc, ins_word,
        output dat_valid, dat_addr, dat_data, dat_we,
        output out_ready,
        input  out_valid, out_entry, level, drop_cnt, state
    );
endinterface

// File: rtl/hfrv_trace_fifo.sv
// Generic first-word-fall-through FIFO; head word is presented combinationally.
module hfrv_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [LVL_W-1:0] r_level;
    logic             w_rd;
    logic             w_wr;

    // A write into a full FIFO is legal only when the head leaves on the same edge.
    assign w_rd = i_rd_en && !i_flush && (r_level != {LVL_W{1'b0}});
    assign w_wr = i_wr_en && !i_flush && ((r_level != LVL_FULL) || w_rd);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_level <= {LVL_W{1'b0}};
        end else if (i_flush) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_level <= {LVL_W{1'b0}};
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_wr);
            r_rptr  <= r_rptr + PTR_W'(w_rd);
            r_level <= r_level + LVL_W'(w_wr) - LVL_W'(w_rd);
        end
    end

    // Storage array, deliberately left without reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rptr];
    assign o_level   = r_level;

endmodule

// File: rtl/hfrv_trace_buffer.sv
// Trace capture top: mode FSM, instruction/data arbiter, pending slot and drop counter.
module hfrv_trace_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    hfrv_trace_buffer_if.slave  bus
);
    import hfrv_trace_pkg::*;

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = 2 + ADDR_W + DATA_W;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef struct packed {
        logic              ch;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    trace_state_t      r_state;
    trace_state_t      w_state_nxt;
    logic              r_trig_mode;
    logic              r_pend_vld;
    entry_t            r_pend;
    logic [DROP_W-1:0] r_drop;

    logic              w_cap;
    logic              w_armed;
    logic              w_match;
    logic              w_ins_acc;
    logic              w_dat_acc;
    entry_t            w_ins_ent;
    entry_t            w_dat_ent;
    entry_t            w_wr_ent;
    logic              w_has_wr;
    logic              w_wr;
    logic              w_rd;
    logic              w_full;
    logic              w_pend_vld_nxt;
    entry_t            w_pend_nxt;
    logic [1:0]        w_drops;
    logic [LVL_W-1:0]  w_level;
    logic [LVL_W-1:0]  w_level_nxt;
    logic [ENT_W-1:0]  w_rd_data;
    logic              w_out_valid;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a, input logic [1:0] b);
        logic [DROP_W:0] sum;
        sum = {1'b0, a} + (DROP_W+1)'(b);
        if (sum[DROP_W]) begin
            return {DROP_W{1'b1}};
        end else begin
            return sum[DROP_W-1:0];
        end
    endfunction

    // FSM state register; the trigger flag remembers which mode started the capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_OFF;
            r_trig_mode <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.cfg_start && !bus.cfg_stop) begin
                r_trig_mode <= (trace_mode_t'(bus.cfg_mode) == MODE_TRIGGER);
            end
        end
    end

    // FSM next-state: stop beats start, start beats everything else.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.cfg_stop) begin
            w_state_nxt = ST_OFF;
        end else if (bus.cfg_start) begin
            w_state_nxt = start_state(trace_mode_t'(bus.cfg_mode));
        end else begin
            case (r_state)
                ST_ARMED:   w_state_nxt = w_match ? ST_CAPTURE : ST_ARMED;
                ST_CAPTURE: w_state_nxt = (r_trig_mode && (w_level_nxt == LVL_FULL)) ? ST_FROZEN : ST_CAPTURE;
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    // FSM output decode.
    always_comb begin
        w_cap   = (r_state == ST_CAPTURE);
        w_armed = (r_state == ST_ARMED);
    end

    assign w_match   = w_armed && bus.ins_valid && (bus.ins_pc == bus.trig_pc);
    assign w_ins_acc = bus.ins_valid && (w_cap || w_match);
    assign w_dat_acc = bus.dat_valid && w_cap;
    assign w_ins_ent = '{ch: CH_INS, we: 1'b0, addr: bus.ins_pc, data: bus.ins_word};
    assign w_dat_ent = '{ch: CH_DAT, we: bus.dat_we, addr: bus.dat_addr, data: bus.dat_data};
    assign w_rd      = w_out_valid && bus.out_ready;
    assign w_full    = (w_level == LVL_FULL);

    // Arbiter: instruction first, then the pended data word, then fresh data.
    always_comb begin
        w_has_wr       = 1'b0;
        w_wr_ent       = w_ins_ent;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_nxt     = r_pend;
        w_drops        = 2'd0;
        if (w_ins_acc) begin
            w_has_wr = 1'b1;
            w_wr_ent = w_ins_ent;
        end else if (w_cap && r_pend_vld) begin
            w_has_wr = 1'b1;
            w_wr_ent = r_pend;
        end else if (w_dat_acc) begin
            w_has_wr = 1'b1;
            w_wr_ent = w_dat_ent;
        end else begin
            w_has_wr = 1'b0;
        end
        w_wr = w_has_wr && (!w_full || w_rd);
        if (w_ins_acc) begin
            w_drops = {1'b0, !w_wr};
            if (w_dat_acc && r_pend_vld) begin
                w_drops = w_drops + 2'd1;
            end else if (w_dat_acc) begin
                w_pend_vld_nxt = 1'b1;
                w_pend_nxt     = w_dat_ent;
            end else begin
                w_pend_vld_nxt = r_pend_vld;
            end
        end else if (w_cap && r_pend_vld) begin
            if (w_wr) begin
                w_pend_vld_nxt = w_dat_acc;
                w_pend_nxt     = w_dat_ent;
            end else begin
                w_drops = {1'b0, w_dat_acc};
            end
        end else begin
            w_drops = {1'b0, w_has_wr && !w_wr};
        end
    end

    // Occupancy after this edge, used to freeze a triggered capture once it fills.
    always_comb begin
        if (bus.cfg_flush) begin
            w_level_nxt = {LVL_W{1'b0}};
        end else begin
            w_level_nxt = w_level + LVL_W'(w_wr) - LVL_W'(w_rd);
        end
    end

    // Pending slot and saturating drop counter; flush discards this cycle's activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld <= 1'b0;
            r_pend     <= '0;
            r_drop     <= {DROP_W{1'b0}};
        end else if (bus.cfg_flush) begin
            r_pend_vld <= 1'b0;
            r_pend     <= '0;
            r_drop     <= {DROP_W{1'b0}};
        end else begin
            r_pend_vld <= w_pend_vld_nxt;
            r_pend     <= w_pend_nxt;
            r_drop     <= sat_add(r_drop, w_drops);
        end
    end

    hfrv_trace_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr),
        .i_wr_data (w_wr_ent),
        .i_rd_en   (w_rd),
        .i_flush   (bus.cfg_flush),
        .o_rd_data (w_rd_data),
        .o_level   (w_level)
    );

    assign w_out_valid   = (w_level != {LVL_W{1'b0}});
    assign bus.out_valid = w_out_valid;
    assign bus.out_entry = w_out_valid ? w_rd_data : {ENT_W{1'b0}};
    assign bus.level     = w_level;
    assign bus.drop_cnt  = r_drop;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_hfrv_trace_buffer.sv
// Directed plus randomized bench for hfrv_trace_buffer against a queue-based reference model.
module tb_hfrv_trace_buffer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 4;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    hfrv_trace_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) tif ();

    hfrv_trace_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue contents, pending slot, drop count, state number, trigger flag.
    logic [65:0] mq[$];
    logic [65:0] pq[$];
    int          m_state;
    int          m_drop;
    bit          m_trig;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pq.delete();
        m_state = 0;
        m_drop  = 0;
        m_trig  = 1'b0;
    endtask

    task automatic model_cycle();
        int          n_drop;
        bit          rd;
        bit          cap;
        bit          hit;
        bit          ins_t;
        bit          dat_t;
        logic [65:0] ie;
        logic [65:0] de;
        n_drop = 0;
        rd  = (mq.size() > 0) && tif.out_ready;
        cap = (m_state == 2);
        hit = (m_state == 1) && tif.ins_valid && (tif.ins_pc == tif.trig_pc);
        ie  = {1'b0, 1'b0, tif.ins_pc, tif.ins_word};
        de  = {1'b1, tif.dat_we, tif.dat_addr, tif.dat_data};
        if (tif.cfg_flush) begin
            mq.delete();
            pq.delete();
            m_drop = 0;
        end else begin
            if (rd) void'(mq.pop_front());
            ins_t = tif.ins_valid && (cap || hit);
            dat_t = tif.dat_valid && cap;
            if (ins_t) begin
                if (mq.size() < DEPTH) mq.push_back(ie);
                else n_drop++;
                if (dat_t) begin
                    if (pq.size() > 0) n_drop++;
                    else pq.push_back(de);
                end
            end else if (cap && pq.size() > 0) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(pq.pop_front());
                    if (dat_t) pq.push_back(de);
                end else if (dat_t) begin
                    n_drop++;
                end
            end else if (dat_t) begin
                if (mq.size() < DEPTH) mq.push_back(de);
                else n_drop++;
            end
            m_drop = (m_drop + n_drop > DROP_MAX) ? DROP_MAX : m_drop + n_drop;
        end
        if (tif.cfg_stop) begin
            m_state = 0;
        end else if (tif.cfg_start) begin
            m_state = (tif.cfg_mode == 2'd1) ? 2 : (tif.cfg_mode == 2'd2) ? 1 : 0;
            m_trig  = (tif.cfg_mode == 2'd2);
        end else if (hit) begin
            m_state = 2;
        end else if (m_state == 2 && m_trig && mq.size() == DEPTH) begin
            m_state = 3;
        end
    endtask

    task automatic check_all();
        chk("state", tif.state, m_state);
        chk("level", tif.level, mq.size());
        chk("out_valid", tif.out_valid, mq.size() > 0);
        chk("out_entry", tif.out_entry, (mq.size() > 0) ? mq[0] : 66'd0);
        chk("drop_cnt", tif.drop_cnt, m_drop);
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        tif.cfg_start = 1'b0;
        tif.cfg_stop  = 1'b0;
        tif.cfg_flush = 1'b0;
        tif.ins_valid = 1'b0;
        tif.dat_valid = 1'b0;
        tif.dat_we    = 1'b0;
    endtask

    task automatic send_ins(input logic [31:0] pc);
        tif.ins_valid = 1'b1;
        tif.ins_pc    = pc;
        tif.ins_word  = ~pc;
        step();
        tif.ins_valid = 1'b0;
    endtask

    task automatic start(input logic [1:0] mode);
        tif.cfg_mode  = mode;
        tif.cfg_start = 1'b1;
        step();
        tif.cfg_start = 1'b0;
    endtask

    task automatic flush();
        tif.cfg_flush = 1'b1;
        step();
        tif.cfg_flush = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst_n = 1'b0;
        tif.cfg_mode  = 2'd0;
        tif.trig_pc   = 32'h0;
        tif.ins_pc    = 32'h0;
        tif.ins_word  = 32'h0;
        tif.dat_addr  = 32'h0;
        tif.dat_data  = 32'h0;
        tif.out_ready = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // STREAM burst
        start(2'd1);
        for (int i = 0; i < 5; i++) send_ins(32'h100 + 32'(4 * i));
        chk("burst_level", tif.level, 5);
        chk("burst_head_pc", tif.out_entry[63:32], 32'h100);
        chk("burst_head_ch", tif.out_entry[65], 1'b0);
        tif.out_ready = 1'b1;
        repeat (5) step();
        tif.out_ready = 1'b0;
        chk("burst_drained", tif.level, 0);

        // Collision: instruction and data in the same cycle
        tif.ins_valid = 1'b1;
        tif.ins_pc    = 32'h200;
        tif.ins_word  = 32'h1234_5678;
        tif.dat_valid = 1'b1;
        tif.dat_addr  = 32'h8000;
        tif.dat_data  = 32'hDEAD;
        tif.dat_we    = 1'b1;
        step();
        set_idle();
        chk("coll_first", tif.out_entry, {1'b0, 1'b0, 32'h200, 32'h1234_5678});
        step();
        chk("coll_level", tif.level, 2);
        chk("coll_drop", tif.drop_cnt, 0);
        tif.out_ready = 1'b1;
        step();
        chk("coll_second", tif.out_entry, {1'b1, 1'b1, 32'h8000, 32'hDEAD});
        step();
        tif.out_ready = 1'b0;

        // Overflow in STREAM
        for (int i = 0; i < 20; i++) send_ins(32'h1000 + 32'(4 * i));
        chk("ovf_level", tif.level, 16);
        chk("ovf_drop", tif.drop_cnt, 4);
        chk("ovf_head", tif.out_entry[63:32], 32'h1000);
        tif.out_ready = 1'b1;
        repeat (16) step();
        tif.out_ready = 1'b0;
        flush();
        chk("ovf_flushed_drop", tif.drop_cnt, 0);

        // TRIGGER
        tif.trig_pc = 32'h40;
        start(2'd2);
        chk("trig_armed", tif.state, 1);
        send_ins(32'h30);
        send_ins(32'h34);
        chk("trig_pre_level", tif.level, 0);
        send_ins(32'h40);
        chk("trig_capture", tif.state, 2);
        chk("trig_first", tif.out_entry[63:32], 32'h40);
        send_ins(32'h44);
        chk("trig_level2", tif.level, 2);
        for (int i = 0; i < 14; i++) send_ins(32'h48 + 32'(4 * i));
        chk("trig_frozen", tif.state, 3);
        tif.dat_valid = 1'b1;
        for (int i = 0; i < 3; i++) send_ins(32'h900 + 32'(4 * i));
        set_idle();
        chk("frozen_drop", tif.drop_cnt, 0);
        chk("frozen_level", tif.level, 16);
        tif.out_ready = 1'b1;
        repeat (2) step();
        tif.out_ready = 1'b0;
        chk("frozen_stays", tif.state, 3);

        // Control races
        tif.cfg_mode  = 2'd1;
        tif.cfg_start = 1'b1;
        tif.cfg_stop  = 1'b1;
        step();
        set_idle();
        chk("start_stop", tif.state, 0);
        start(2'd1);
        for (int i = 0; i < 3; i++) send_ins(32'h300 + 32'(4 * i));
        tif.cfg_flush = 1'b1;
        tif.ins_valid = 1'b1;
        tif.out_ready = 1'b1;
        step();
        set_idle();
        tif.out_ready = 1'b0;
        chk("flush_race_level", tif.level, 0);
        chk("flush_race_drop", tif.drop_cnt, 0);
        for (int i = 0; i < 33; i++) send_ins(32'h500 + 32'(4 * i));
        chk("drop_saturate", tif.drop_cnt, 15);
        flush();

        // Asynchronous reset in the middle of a capture
        for (int i = 0; i < 7; i++) send_ins(32'h700 + 32'(4 * i));
        chk("pre_reset_level", tif.level, 7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_level", tif.level, 0);
        chk("rst_valid", tif.out_valid, 1'b0);
        chk("rst_entry", tif.out_entry, 66'd0);
        chk("rst_drop", tif.drop_cnt, 0);
        chk("rst_state", tif.state, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            tif.ins_valid = ($urandom_range(0, 1) == 1);
            tif.ins_pc    = ($urandom_range(0, 5) == 0) ? 32'h40 : 32'($urandom_range(0, 63)) << 2;
            tif.ins_word  = $urandom;
            tif.dat_valid = ($urandom_range(0, 1) == 1);
            tif.dat_addr  = $urandom;
            tif.dat_data  = $urandom;
            tif.dat_we    = ($urandom_range(0, 1) == 1);
            tif.out_ready = ($urandom_range(0, 9) < 4);
            tif.cfg_mode  = 2'($urandom_range(0, 3));
            tif.cfg_start = ($urandom_range(0, 31) == 0);
            tif.cfg_stop  = ($urandom_range(0, 63) == 0);
            tif.cfg_flush = ($urandom_range(0, 47) == 0);
            step();
        end
        set_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
